uart_word_loader: RTL and testbench
===================================

Name: uart_word_loader

Overview:
- Parametrised successor to the fixed 12 Mbaud byte-to-48-bit loader.
- Receives 8N1 serial bytes from a host COM port and validates the start and stop bits.
- Packs BYTES_PER_WORD bytes, little-endian, into one word and emits it with an auto-incrementing write address for the framebuffer/memory loader.
- Adds false-start rejection, framing-error detection, and idle-timeout word resynchronisation.

Parameters:
- CLK_DIV, 25, clk cycles per serial bit (300 MHz / 12 Mbaud); must be >= 4.
- BYTES_PER_WORD, 6, bytes packed per output word; must be >= 1.
- ADDR_W, 18, write-address width.
- ADDR_INIT, 0, address loaded on reset.
- IDLE_BITS, 20, idle-line time in bit periods that discards a partial word.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in  in  1  asynchronous serial RX line; idle high.
- rx_byte  out  1  one-cycle strobe: a valid byte was received.
- byte_q  out  8  last valid byte; held between strobes.
- word_valid  out  1  one-cycle strobe: word Q / address A ready.
- Q  out  8*BYTES_PER_WORD  packed word; the first received byte sits in bits [7:0].
- A  out  ADDR_W  address for the current Q; held until the next word_valid.
- frame_err  out  1  one-cycle strobe: stop bit sampled low.
- sync_err  out  1  one-cycle strobe: partial word discarded by idle timeout.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: all outputs 0 except A = ADDR_INIT; FSM = IDLE; byte index = 0; next address = ADDR_INIT.
- Reset mid-frame aborts the frame immediately, with no strobes.
- Input synchronisation: `in` passes through a 2-FF synchroniser.
- Falling-edge detection uses the synchronised value and its 1-cycle delayed copy.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - A synced falling edge -> START, bit counter = 0.
  - Idle counter increments each cycle the line is high; it clears on any START.
- START:
  - Sample at bit counter = CLK_DIV/2 - 1 (integer division).
  - Line high -> false start, return to IDLE, no strobe.
  - Line low -> DATA, bit counter = 0, bit index = 0.
- DATA:
  - Sample at bit counter = CLK_DIV - 1, then reset the counter.
  - Shift LSB-first into an 8-bit register.
  - After bit 7 -> STOP.
- STOP: sample after CLK_DIV cycles.
  - High -> byte accepted, go to IDLE.
  - Low -> frame_err, byte discarded, byte index unchanged, go to BREAK.
- BREAK: wait until the synced line is high, then go to IDLE; a low line is not treated as a start.
- Byte acceptance:
  - rx_byte and byte_q update in the cycle after the stop-bit sample.
  - The byte is written into word-assembly slot [byte index].
- Word completion:
  - On accepting the byte at index BYTES_PER_WORD-1, in the same cycle as rx_byte:
    - Q <= assembled word, including the new byte.
    - A <= next address.
    - word_valid = 1.
    - next address increments, byte index = 0.
  - Otherwise the byte index increments.
- Address arithmetic: modulo 2^ADDR_W; wrap from all-ones to 0 is silent.
- Idle timeout:
  - Trigger: in IDLE, idle counter reaches IDLE_BITS*CLK_DIV while byte index != 0.
  - Action: sync_err pulses, byte index = 0, partial word discarded, address unchanged.
  - The counter saturates; sync_err fires once per idle period.
- Word-to-word spacing: back-to-back frames (stop bit directly followed by a start bit) must be received with no loss.
- Latency: last stop-bit sample to word_valid = 1 cycle, plus 2 cycles of synchroniser delay from the line.
- Strobe exclusivity: rx_byte/word_valid and frame_err never assert in the same cycle.

Test Plan:
- Six frames 0x01..0x06, back-to-back, default params -> six rx_byte pulses; one word_valid with Q = 48'h060504030201, A = 0. A further six frames give A = 1.
- Low glitch of 0.3 bit (7 clks) on an idle line -> no rx_byte, no frame_err, FSM back in IDLE.
- Frame 0x55 with stop bit forced low, then frame 0xAA -> frame_err once, no rx_byte for 0x55. Line held low 3 bits after the bad stop produces no false byte. 0xAA is accepted as byte index 0.
- Three bytes, then the line idle 20 bit times -> one sync_err. The next six bytes 0x10..0x15 give Q = 48'h151413121110, A = 0.
- ADDR_W = 2, ADDR_INIT = 3, BYTES_PER_WORD = 1 -> bytes 0xA0, 0xA1 give A = 3, then A = 0 (wrap).
- Reset asserted mid-DATA of the 4th byte -> no strobes; A = ADDR_INIT. Next six full bytes form a complete word at ADDR_INIT.

Source files
------------

// File: rtl/uart_word_loader.sv
// 8N1 serial receiver that packs BYTES_PER_WORD little-endian bytes into one word
// and emits it with an auto-incrementing write address.
module uart_word_loader #(
  parameter int unsigned       CLK_DIV        = 25,
  parameter int unsigned       BYTES_PER_WORD = 6,
  parameter int unsigned       ADDR_W         = 18,
  parameter logic [ADDR_W-1:0] ADDR_INIT      = '0,
  parameter int unsigned       IDLE_BITS      = 20
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in,
  output logic                        rx_byte,
  output logic [7:0]                  byte_q,
  output logic                        word_valid,
  output logic [8*BYTES_PER_WORD-1:0] Q,
  output logic [ADDR_W-1:0]           A,
  output logic                        frame_err,
  output logic                        sync_err
);

  localparam int unsigned CNT_W   = $clog2(CLK_DIV);
  localparam int unsigned TIMEOUT = IDLE_BITS * CLK_DIV;
  localparam int unsigned IDLE_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned IDX_W   = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  localparam logic [CNT_W-1:0]  START_SAMPLE = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0]  BIT_LAST     = CNT_W'(CLK_DIV - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST    = IDLE_W'(TIMEOUT - 1);
  localparam logic [IDLE_W-1:0] IDLE_SAT     = IDLE_W'(TIMEOUT);
  localparam logic [IDX_W-1:0]  LAST_IDX     = IDX_W'(BYTES_PER_WORD - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t state, state_next;

  logic                                 in_meta, in_sync, in_prev;
  logic                                 fall;
  logic [CNT_W-1:0]                     cnt;
  logic [2:0]                           bit_idx;
  logic [7:0]                           shreg;
  logic [IDLE_W-1:0]                    idle_cnt;
  logic [IDX_W-1:0]                     byte_idx;
  logic [ADDR_W-1:0]                    next_addr;
  logic [BYTES_PER_WORD-1:0][7:0]       word_buf;
  logic [BYTES_PER_WORD-1:0][7:0]       word_next;

  logic cnt_clr, shift_en, accept, reject, timeout;

  // Line idles high, so the synchroniser resets high to avoid a phantom start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_meta <= 1'b1;
      in_sync <= 1'b1;
      in_prev <= 1'b1;
    end else begin
      in_meta <= in;
      in_sync <= in_meta;
      in_prev <= in_sync;
    end
  end

  assign fall = in_prev & ~in_sync;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    shift_en   = 1'b0;
    accept     = 1'b0;
    reject     = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          state_next = START;
          cnt_clr    = 1'b1;
        end
      end
      START: begin
        if (cnt == START_SAMPLE) begin
          cnt_clr    = 1'b1;
          state_next = in_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_clr = 1'b1;
          if (in_sync) begin
            accept     = 1'b1;
            state_next = IDLE;
          end else begin
            reject     = 1'b1;
            state_next = BREAK;
          end
        end
      end
      BREAK: begin
        if (in_sync) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (cnt_clr || state == IDLE || state == BREAK) cnt <= '0;
      else                                            cnt <= cnt + 1'b1;
      if (state != DATA)  bit_idx <= '0;
      else if (shift_en)  bit_idx <= bit_idx + 1'b1;
      if (shift_en) shreg <= {in_sync, shreg[7:1]};
    end
  end

  // Saturating idle-line timer; sync_err fires only on the step into saturation.
  always_ff @(posedge clk) begin
    if (reset)                                   idle_cnt <= '0;
    else if (state != IDLE || fall)              idle_cnt <= '0;
    else if (in_sync && idle_cnt != IDLE_SAT)    idle_cnt <= idle_cnt + 1'b1;
  end

  assign timeout = (state == IDLE) && !fall && in_sync &&
                   (idle_cnt == IDLE_LAST) && (byte_idx != '0);

  always_comb begin
    word_next           = word_buf;
    word_next[byte_idx] = shreg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_byte    <= 1'b0;
      byte_q     <= '0;
      word_valid <= 1'b0;
      Q          <= '0;
      A          <= ADDR_INIT;
      frame_err  <= 1'b0;
      sync_err   <= 1'b0;
      byte_idx   <= '0;
      next_addr  <= ADDR_INIT;
      word_buf   <= '0;
    end else begin
      rx_byte    <= accept;
      word_valid <= 1'b0;
      frame_err  <= reject;
      sync_err   <= timeout;
      if (accept) begin
        byte_q   <= shreg;
        word_buf <= word_next;
        if (byte_idx == LAST_IDX) begin
          Q          <= word_next;
          A          <= next_addr;
          word_valid <= 1'b1;
          next_addr  <= next_addr + 1'b1;
          byte_idx   <= '0;
        end else begin
          byte_idx <= byte_idx + 1'b1;
        end
      end else if (timeout) begin
        byte_idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_word_loader.sv
// Scoreboard bench for uart_word_loader: stimulus pushes expected bytes/words,
// a negedge monitor pops and compares whenever the DUTs strobe.
module tb_uart_word_loader;

  localparam int CD = 25;

  typedef struct packed {
    logic [47:0] q;
    logic [17:0] a;
  } word_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        line0 = 1'b1;
  logic        line1 = 1'b1;

  logic        rx_byte0, word_valid0, frame_err0, sync_err0;
  logic [7:0]  byte_q0;
  logic [47:0] Q0;
  logic [17:0] A0;

  logic        rx_byte1, word_valid1, frame_err1, sync_err1;
  logic [7:0]  byte_q1;
  logic [7:0]  Q1;
  logic [1:0]  A1;

  always #5 clk = ~clk;

  uart_word_loader #(
    .CLK_DIV(CD), .BYTES_PER_WORD(6), .ADDR_W(18), .ADDR_INIT(18'd0), .IDLE_BITS(20)
  ) u_dut0 (
    .clk(clk), .reset(reset), .in(line0),
    .rx_byte(rx_byte0), .byte_q(byte_q0), .word_valid(word_valid0),
    .Q(Q0), .A(A0), .frame_err(frame_err0), .sync_err(sync_err0)
  );

  uart_word_loader #(
    .CLK_DIV(CD), .BYTES_PER_WORD(1), .ADDR_W(2), .ADDR_INIT(2'd3), .IDLE_BITS(20)
  ) u_dut1 (
    .clk(clk), .reset(reset), .in(line1),
    .rx_byte(rx_byte1), .byte_q(byte_q1), .word_valid(word_valid1),
    .Q(Q1), .A(A1), .frame_err(frame_err1), .sync_err(sync_err1)
  );

  int checks = 0;
  int passes = 0;

  logic [7:0] eb0[$], eb1[$];
  word_t      ew0[$], ew1[$];
  int exp_ferr0, seen_ferr0, exp_serr0, seen_serr0;
  int seen_ferr1, seen_serr1;

  // Reference model state
  logic [7:0]  part0[6];
  int          idx0;
  int          addr0, addr1;
  logic [7:0]  last_b0, last_b1;
  word_t       last_w0, last_w1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void model_reset();
    idx0 = 0; addr0 = 0; addr1 = 3;
    last_b0 = 8'h00; last_b1 = 8'h00;
    last_w0 = '0; last_w1 = '{q: 48'h0, a: 18'd3};
    exp_ferr0 = 0; seen_ferr0 = 0; exp_serr0 = 0; seen_serr0 = 0;
    seen_ferr1 = 0; seen_serr1 = 0;
  endfunction

  function automatic void model_byte(input int d, input logic [7:0] b);
    word_t w;
    if (d == 0) begin
      eb0.push_back(b);
      last_b0 = b;
      part0[idx0] = b;
      idx0++;
      if (idx0 == 6) begin
        w.q = '0;
        for (int i = 0; i < 6; i++) w.q = w.q | (48'(part0[i]) << (8 * i));
        w.a = 18'(addr0);
        ew0.push_back(w);
        last_w0 = w;
        addr0 = (addr0 + 1) % (1 << 18);
        idx0 = 0;
      end
    end else begin
      eb1.push_back(b);
      last_b1 = b;
      w.q = 48'(b);
      w.a = 18'(addr1);
      ew1.push_back(w);
      last_w1 = w;
      addr1 = (addr1 + 1) % 4;
    end
  endfunction

  // Monitor
  always @(negedge clk) begin
    word_t w;
    if (!reset) begin
      if (rx_byte0) begin
        check("dut0 rx_byte expected", 64'(eb0.size() != 0), 64'd1);
        if (eb0.size() != 0) check("dut0 byte_q", byte_q0, eb0.pop_front());
      end
      if (word_valid0) begin
        check("dut0 word_valid expected", 64'(ew0.size() != 0), 64'd1);
        if (ew0.size() != 0) begin
          w = ew0.pop_front();
          check("dut0 Q", Q0, w.q);
          check("dut0 A", A0, w.a);
        end
        check("dut0 word_valid with rx_byte", rx_byte0, 1);
      end
      if (frame_err0) begin
        seen_ferr0++;
        check("dut0 frame_err exclusive", rx_byte0 | word_valid0, 0);
      end
      if (sync_err0) seen_serr0++;
      if (rx_byte1) begin
        check("dut1 rx_byte expected", 64'(eb1.size() != 0), 64'd1);
        if (eb1.size() != 0) check("dut1 byte_q", byte_q1, eb1.pop_front());
      end
      if (word_valid1) begin
        check("dut1 word_valid expected", 64'(ew1.size() != 0), 64'd1);
        if (ew1.size() != 0) begin
          w = ew1.pop_front();
          check("dut1 Q", Q1, w.q);
          check("dut1 A", A1, w.a);
        end
      end
      if (frame_err1) seen_ferr1++;
      if (sync_err1) seen_serr1++;
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int d, input logic v);
    if (d == 0) line0 = v;
    else        line1 = v;
  endtask

  // Leaves the line at the stop-bit level; the caller decides what follows.
  task automatic send_frame(input int d, input logic [7:0] b, input logic stop);
    if (stop) model_byte(d, b);
    else if (d == 0) exp_ferr0++;
    set_line(d, 1'b0);
    hold(CD);
    for (int i = 0; i < 8; i++) begin
      set_line(d, b[i]);
      hold(CD);
    end
    set_line(d, stop);
    hold(CD);
  endtask

  task automatic idle_gap(input int d, input int bits);
    set_line(d, 1'b1);
    if (d == 0 && bits >= 25 && idx0 != 0) begin
      exp_serr0++;
      idx0 = 0;
    end
    hold(bits * CD);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    line0 = 1'b1;
    line1 = 1'b1;
    hold(3);
    reset = 1'b0;
    model_reset();
    hold(2);
  endtask

  task automatic reset_checks();
    check("reset rx_byte", rx_byte0, 0);
    check("reset byte_q", byte_q0, 0);
    check("reset word_valid", word_valid0, 0);
    check("reset Q", Q0, 0);
    check("reset A", A0, 0);
    check("reset frame_err", frame_err0, 0);
    check("reset sync_err", sync_err0, 0);
    check("reset dut1 A", A1, 3);
  endtask

  task automatic drain(input string tag);
    idle_gap(0, 30);
    check({tag, " dut0 bytes outstanding"}, eb0.size(), 0);
    check({tag, " dut0 words outstanding"}, ew0.size(), 0);
    check({tag, " dut0 frame_err count"}, seen_ferr0, exp_ferr0);
    check({tag, " dut0 sync_err count"}, seen_serr0, exp_serr0);
    check({tag, " dut0 byte_q held"}, byte_q0, last_b0);
    check({tag, " dut0 Q held"}, Q0, last_w0.q);
    check({tag, " dut0 A held"}, A0, last_w0.a);
    check({tag, " dut1 bytes outstanding"}, eb1.size(), 0);
    check({tag, " dut1 words outstanding"}, ew1.size(), 0);
    check({tag, " dut1 error strobes"}, seen_ferr1 + seen_serr1, 0);
    check({tag, " dut1 A held"}, A1, last_w1.a);
  endtask

  initial begin
    logic [7:0] b;
    int r;

    // Back-to-back frames, two words
    do_reset();
    reset_checks();
    for (int i = 1; i <= 6; i++) send_frame(0, 8'(i), 1'b1);
    for (int i = 0; i < 6; i++) send_frame(0, 8'($urandom_range(0, 255)), 1'b1);
    drain("b2b");

    // Short low glitch on an idle line
    do_reset();
    line0 = 1'b0;
    hold(7);
    line0 = 1'b1;
    hold(3 * CD);
    for (int i = 0; i < 6; i++) send_frame(0, 8'($urandom_range(0, 255)), 1'b1);
    drain("glitch");

    // Framing error, line held low afterwards, then a good byte at index 0
    do_reset();
    send_frame(0, 8'h55, 1'b0);
    hold(3 * CD);
    idle_gap(0, 2);
    send_frame(0, 8'hAA, 1'b1);
    for (int i = 0; i < 5; i++) send_frame(0, 8'($urandom_range(0, 255)), 1'b1);
    drain("frame_err");

    // Idle timeout discards a partial word
    do_reset();
    for (int i = 0; i < 3; i++) send_frame(0, 8'($urandom_range(0, 255)), 1'b1);
    idle_gap(0, 25);
    for (int i = 0; i < 6; i++) send_frame(0, 8'(8'h10 + i), 1'b1);
    drain("timeout");

    // Reset in the middle of the 4th byte's data bits
    do_reset();
    for (int i = 0; i < 15; i++) send_frame(0, 8'($urandom_range(0, 255)), 1'b1);
    b = 8'($urandom_range(0, 255));
    line0 = 1'b0;
    hold(CD);
    for (int i = 0; i < 3; i++) begin
      line0 = b[i];
      hold(CD);
    end
    line0 = b[3];
    hold(CD / 2);
    do_reset();
    reset_checks();
    hold(3 * CD);
    for (int i = 0; i < 6; i++) send_frame(0, 8'($urandom_range(0, 255)), 1'b1);
    drain("midreset");

    // Narrow address wraps on the single-byte-word instance
    do_reset();
    reset_checks();
    send_frame(1, 8'hA0, 1'b1);
    idle_gap(1, 1);
    send_frame(1, 8'hA1, 1'b1);
    for (int i = 0; i < 4; i++) send_frame(1, 8'($urandom_range(0, 255)), 1'b1);
    idle_gap(1, 1);
    drain("wrap");

    // Random soak: bad stops, short and long gaps
    do_reset();
    for (int n = 0; n < 40; n++) begin
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) begin
        send_frame(0, b, 1'b0);
        hold($urandom_range(0, 3) * CD);
        idle_gap(0, $urandom_range(1, 3));
      end else begin
        send_frame(0, b, 1'b1);
        r = $urandom_range(0, 9);
        if (r < 7) idle_gap(0, $urandom_range(0, 3));
        else       idle_gap(0, 25);
      end
    end
    drain("soak");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
